// File: rtl/regfile_writeback_queue_if.sv
// Handshake bundle for the register-file writeback queue: two completion sources,
// issue controls, the registered write/release port and queue status.
interface regfile_writeback_queue_if #(
   parameter int unsigned PTR_W = 2
);
   logic              src0_valid;
   logic              src0_ready;
   logic [4:0]        src0_addr;
   logic [47:0]       src0_data;
   logic              src1_valid;
   logic              src1_ready;
   logic [4:0]        src1_addr;
   logic [47:0]       src1_data;
   logic              stall;
   logic              flush;
   logic              write_enable;
   logic [4:0]        write_addr;
   logic [47:0]       write_data;
   logic              release_enable;
   logic [4:0]        release_addr;
   logic [PTR_W:0]    occupancy;
   logic              full;
   logic              empty;

   modport master (
      output src0_valid, src0_addr, src0_data,
      output src1_valid, src1_addr, src1_data,
      output stall, flush,
      input  src0_ready, src1_ready,
      input  write_enable, write_addr, write_data,
      input  release_enable, release_addr,
      input  occupancy, full, empty
   );

   modport slave (
      input  src0_valid, src0_addr, src0_data,
      input  src1_valid, src1_addr, src1_data,
      input  stall, flush,
      output src0_ready, src1_ready,
      output write_enable, write_addr, write_data,
      output release_enable, release_addr,
      output occupancy, full, empty
   );
endinterface

// File: rtl/regfile_writeback_queue.sv
// Writeback queue: round-robin arbitration of ALU/MEM completions into a FIFO that
// issues one registered register-file write plus scoreboard release per cycle.
module regfile_writeback_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input logic                      clk,
   input logic                      reset,
   regfile_writeback_queue_if.slave bus
);
   localparam logic [PTR_W:0] FullCnt = DEPTH[PTR_W:0];

   logic [4:0]       addr_mem_q [DEPTH];
   logic [47:0]      data_mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             rr_q, rr_d;  // 1: src1 wins the next tie
   logic             we_q, we_d;
   logic [4:0]       waddr_q, waddr_d;
   logic [47:0]      wdata_q, wdata_d;

   logic             full, empty, can_grant;
   logic             gnt0, gnt1, push, pop;
   logic [4:0]       push_addr;
   logic [47:0]      push_data;

   always_comb begin
      full      = (cnt_q == FullCnt);
      empty     = (cnt_q == '0);
      can_grant = !full && !bus.flush;
      gnt0      = can_grant && bus.src0_valid && (!bus.src1_valid || !rr_q);
      gnt1      = can_grant && bus.src1_valid && (!bus.src0_valid || rr_q);
      push_addr = gnt1 ? bus.src1_addr : bus.src0_addr;
      push_data = gnt1 ? bus.src1_data : bus.src0_data;
      // Address 0 is accepted but dropped: r0 is never written or released
      push      = (gnt0 || gnt1) && (push_addr != 5'd0);
      pop       = !empty && !bus.stall && !bus.flush;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      rr_d     = rr_q;
      we_d     = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (gnt0) begin
            rr_d = 1'b1;
         end else if (gnt1) begin
            rr_d = 1'b0;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            we_d     = 1'b1;
            waddr_d  = addr_mem_q[rd_ptr_q];
            wdata_d  = data_mem_q[rd_ptr_q];
         end
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         rr_q     <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         rr_q     <= rr_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         addr_mem_q[wr_ptr_q] <= push_addr;
         data_mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_comb begin
      bus.src0_ready     = gnt0;
      bus.src1_ready     = gnt1;
      bus.write_enable   = we_q;
      bus.write_addr     = waddr_q;
      bus.write_data     = wdata_q;
      bus.release_enable = we_q;
      bus.release_addr   = waddr_q;
      bus.occupancy      = cnt_q;
      bus.full           = full;
      bus.empty          = empty;
   end
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue with hand-computed expectations.
module tb_regfile_writeback_queue;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   regfile_writeback_queue_if #(.PTR_W(2)) bus ();

   regfile_writeback_queue #(.DEPTH(4), .PTR_W(2)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.src0_valid = 1'b0;
      bus.src0_addr  = '0;
      bus.src0_data  = '0;
      bus.src1_valid = 1'b0;
      bus.src1_addr  = '0;
      bus.src1_data  = '0;
      bus.stall      = 1'b0;
      bus.flush      = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic check_write(input string tag, input logic [4:0] a, input logic [47:0] d);
      check({tag, "_we"}, bus.write_enable, 1);
      check({tag, "_re"}, bus.release_enable, 1);
      check({tag, "_wa"}, bus.write_addr, a);
      check({tag, "_ra"}, bus.release_addr, a);
      check({tag, "_wd"}, bus.write_data, d);
   endtask

   // Invariants on every cycle out of reset
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         check("occ_bound", bus.occupancy <= 3'd4, 1);
         check("en_match", bus.write_enable, bus.release_enable);
      end
   end

   initial begin
      idle_inputs();
      reset = 1'b1;

      // 1: reset state
      step();
      step();
      check("rst_we", bus.write_enable, 0);
      check("rst_re", bus.release_enable, 0);
      check("rst_occ", bus.occupancy, 0);
      check("rst_empty", bus.empty, 1);
      check("rst_full", bus.full, 0);
      check("rst_wa", bus.write_addr, 0);
      reset = 1'b0;
      bus.src0_valid = 1'b1;
      #1;
      check("t1_rdy0", bus.src0_ready, 1);
      bus.src0_valid = 1'b0;

      // 2: single entry latency
      do_reset();
      bus.src0_valid = 1'b1;
      bus.src0_addr  = 5'd5;
      bus.src0_data  = 48'h123456789ABC;
      #1;
      check("t2_rdy", bus.src0_ready, 1);
      step();
      bus.src0_valid = 1'b0;
      check("t2_we_k", bus.write_enable, 0);
      check("t2_occ_k", bus.occupancy, 1);
      step();
      check_write("t2_k1", 5'd5, 48'h123456789ABC);
      check("t2_occ_k1", bus.occupancy, 0);
      step();
      check("t2_we_k2", bus.write_enable, 0);

      // 3: round-robin between both sources
      do_reset();
      bus.src0_valid = 1'b1;
      bus.src0_addr  = 5'd3;
      bus.src0_data  = 48'h333;
      bus.src1_valid = 1'b1;
      bus.src1_addr  = 5'd7;
      bus.src1_data  = 48'h777;
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("t3_rdy0_%0d", i), bus.src0_ready, (i % 2 == 0));
         check($sformatf("t3_rdy1_%0d", i), bus.src1_ready, (i % 2 == 1));
         step();
         if (i >= 1) begin
            if (i % 2 == 1) check_write($sformatf("t3_w%0d", i - 1), 5'd3, 48'h333);
            else check_write($sformatf("t3_w%0d", i - 1), 5'd7, 48'h777);
         end
      end
      bus.src0_valid = 1'b0;
      bus.src1_valid = 1'b0;
      step();
      check_write("t3_w5", 5'd7, 48'h777);
      step();
      check("t3_we_end", bus.write_enable, 0);

      // 4: stall fills the queue, then drains in order
      do_reset();
      bus.stall      = 1'b1;
      bus.src0_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.src0_addr = 5'(10 + i);
         bus.src0_data = 48'(100 + i);
         #1;
         check($sformatf("t4_rdy_%0d", i), bus.src0_ready, 1);
         step();
         check($sformatf("t4_we_%0d", i), bus.write_enable, 0);
      end
      bus.src0_addr = 5'd14;
      bus.src0_data = 48'd104;
      #1;
      check("t4_full", bus.full, 1);
      check("t4_occ", bus.occupancy, 4);
      check("t4_rdy_full", bus.src0_ready, 0);
      step();
      check("t4_occ_hold", bus.occupancy, 4);
      bus.stall = 1'b0;
      #1;
      check("t4_rdy_pop", bus.src0_ready, 0);
      step();
      check_write("t4_w10", 5'd10, 48'd100);
      check("t4_occ3", bus.occupancy, 3);
      check("t4_rdy14", bus.src0_ready, 1);
      step();
      bus.src0_valid = 1'b0;
      check_write("t4_w11", 5'd11, 48'd101);
      check("t4_occ3b", bus.occupancy, 3);
      step();
      check_write("t4_w12", 5'd12, 48'd102);
      step();
      check_write("t4_w13", 5'd13, 48'd103);
      step();
      check_write("t4_w14", 5'd14, 48'd104);
      check("t4_empty", bus.empty, 1);
      step();
      check("t4_we_end", bus.write_enable, 0);

      // 5: address 0 is accepted and dropped
      do_reset();
      bus.src1_valid = 1'b1;
      bus.src1_addr  = 5'd0;
      bus.src1_data  = 48'hFFFF;
      #1;
      check("t5_rdy1", bus.src1_ready, 1);
      step();
      bus.src1_valid = 1'b0;
      check("t5_occ", bus.occupancy, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("t5_we_%0d", i), bus.write_enable, 0);
         check($sformatf("t5_re_%0d", i), bus.release_enable, 0);
      end

      // 6: flush, then reset, discard queued entries
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         bus.stall      = 1'b1;
         bus.src0_valid = 1'b1;
         for (int i = 0; i < 3; i++) begin
            bus.src0_addr = 5'(20 + i);
            step();
         end
         bus.src0_valid = 1'b0;
         check($sformatf("t6_occ3_%0d", pass), bus.occupancy, 3);
         bus.stall = 1'b0;
         if (pass == 0) bus.flush = 1'b1;
         else reset = 1'b1;
         step();
         bus.flush = 1'b0;
         reset     = 1'b0;
         check($sformatf("t6_occ0_%0d", pass), bus.occupancy, 0);
         check($sformatf("t6_empty_%0d", pass), bus.empty, 1);
         check($sformatf("t6_we0_%0d", pass), bus.write_enable, 0);
         step();
         check($sformatf("t6_we1_%0d", pass), bus.write_enable, 0);
         check($sformatf("t6_occ1_%0d", pass), bus.occupancy, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
